// File: rtl/ddr_serdes_pkg.sv
// Shared definitions for the DDR serializer/deserializer pair: default
// geometry, the one-bit FSM encoding and the slice-index width helper.
package ddr_serdes_pkg;

   localparam int D_DEFAULT = 8;
   localparam int S_DEFAULT = 4;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   // Width of a slice index for a word of `value` slices; never below one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serializer_holding_buffer.sv
// One-entry holding register for the serializer: keeps the next word while the
// shifter is still busy with the current one. A push and a pop in the same
// cycle hand the old word out and keep the new one, so order stays FIFO.
module serializer_holding_buffer
   import ddr_serdes_pkg::*;
#(
   parameter int W = D_DEFAULT * S_DEFAULT
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_word,
   input  logic         i_pop,
   output logic [W-1:0] o_word,
   output logic         o_full
);

   logic [W-1:0] r_word;
   logic         r_full;

   // Capture a pushed word; the full flag drops only on a pop without a push.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word <= '0;
         r_full <= 1'b0;
      end else if (i_push) begin
         r_word <= i_word;
         r_full <= 1'b1;
      end else if (i_pop) begin
         r_full <= 1'b0;
      end
   end

   assign o_word = r_word;
   assign o_full = r_full;

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial converter: one D*S-bit word out as S D-bit slices,
// least-significant slice first, one slice per clock.
// Build option: SERIALIZER_IDLE_PATTERN_EN drives IDLE_PATTERN on data_out
// while idle and in reset; otherwise idle data_out is zero.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no live slice; data_out_valid=0, data_out = idle value
//   ST_SHIFT | emitting slice r_cnt (0..S-1) of the word in r_shift
module serializer
   import ddr_serdes_pkg::*;
#(
   parameter int           D            = D_DEFAULT,
   parameter int           S            = S_DEFAULT,
   parameter logic [D-1:0] IDLE_PATTERN = '0
) (
   input  logic             high_speed_clock,
   input  logic             reset_n,
   input  logic [D*S-1:0]   data_in,
   input  logic             data_in_valid,
   output logic             data_in_ready,
   output logic [D-1:0]     data_out,
   output logic             data_out_valid
);

   localparam int W  = D * S;
   localparam int CW = clog2(S);
   localparam logic [CW-1:0] LAST_SLICE = CW'(S - 1);

`ifdef SERIALIZER_IDLE_PATTERN_EN
   localparam logic [D-1:0] IDLE_VALUE = IDLE_PATTERN;
`else
   // Pattern stays in the parameter list for drop-in compatibility but is masked off.
   localparam logic [D-1:0] IDLE_VALUE = IDLE_PATTERN & {D{1'b0}};
`endif

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_shift;

   logic          w_buf_full;
   logic [W-1:0]  w_buf_word;
   logic          w_accept;
   logic          w_last;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;

   // Ready is the registered inverse of the buffer flag, so it never depends on data_in_valid.
   assign data_in_ready = !w_buf_full;
   assign w_accept      = data_in_valid && !w_buf_full;
   assign w_last        = (r_state == ST_SHIFT) && (r_cnt == LAST_SLICE);

   // A new word goes straight to the shifter when the shifter is free at the next edge
   // and nothing older is waiting; otherwise it parks in the holding buffer.
   assign w_bypass = w_accept && ((r_state == ST_IDLE) || (w_last && !w_buf_full));
   assign w_push   = w_accept && !w_bypass;
   assign w_pop    = w_last && w_buf_full;

   serializer_holding_buffer #(
      .W (W)
   ) u_hold (
      .i_clk   (high_speed_clock),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_word  (data_in),
      .i_pop   (w_pop),
      .o_word  (w_buf_word),
      .o_full  (w_buf_full)
   );

   // FSM, slice counter and shifter: load on accept or drain, shift by D otherwise.
   always_ff @(posedge high_speed_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (r_state == ST_IDLE) begin
         r_cnt <= '0;
         if (w_bypass) begin
            r_shift <= data_in;
            r_state <= ST_SHIFT;
         end
      end else begin
         if (w_last) begin
            r_cnt <= '0;
            if (w_pop) begin
               // Buffered word is older than anything arriving now.
               r_shift <= w_buf_word;
            end else if (w_bypass) begin
               r_shift <= data_in;
            end else begin
               r_shift <= '0;
               r_state <= ST_IDLE;
            end
         end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_shift <= r_shift >> D;
         end
      end
   end

   // Outputs come straight from registers; idle slots carry the idle value.
   always_comb begin
      data_out_valid = (r_state == ST_SHIFT);
      data_out       = IDLE_VALUE;
      if (r_state == ST_SHIFT) begin
         data_out = r_shift[D-1:0];
      end
   end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer (D=8, S=4) with a slice scoreboard and a
// word-level deserializer model for the loopback check.
module tb_serializer;

   localparam int D = 8;
   localparam int S = 4;

`ifdef SERIALIZER_IDLE_PATTERN_EN
   localparam logic [D-1:0] IDLE_EXP = 8'hA5;
`else
   localparam logic [D-1:0] IDLE_EXP = 8'h00;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [D*S-1:0] data_in = '0;
   logic           din_valid = 1'b0;
   logic           din_ready;
   logic [D-1:0]   dout;
   logic           dout_valid;

   serializer #(
      .D            (D),
      .S            (S),
      .IDLE_PATTERN (8'hA5)
   ) dut (
      .high_speed_clock (clk),
      .reset_n          (rst_n),
      .data_in          (data_in),
      .data_in_valid    (din_valid),
      .data_in_ready    (din_ready),
      .data_out         (dout),
      .data_out_valid   (dout_valid)
   );

   always #5 clk = ~clk;

   int             n_vec = 0;
   int             n_err = 0;
   logic [D-1:0]   slice_q[$];
   logic [D*S-1:0] word_q[$];
   logic [D*S-1:0] acc = '0;
   int             acc_n = 0;
   logic           mon_en = 1'b0;
   logic [D-1:0]   mon_exp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor and deserializer model, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_n = 0;
      end else if (mon_en) begin
         chk("out_valid", 32'(dout_valid), 32'(slice_q.size() != 0));
         if (slice_q.size() != 0) begin
            mon_exp = slice_q.pop_front();
            chk("slice", 32'(dout), 32'(mon_exp));
         end else begin
            chk("idle_data", 32'(dout), 32'(IDLE_EXP));
         end
         if (dout_valid === 1'b1) begin
            acc   = {dout, acc[D*S-1:D]};
            acc_n = acc_n + 1;
            if (acc_n == S) begin
               acc_n = 0;
               if (word_q.size() == 0) begin
                  chk("deser_extra_word", 32'd1, 32'd0);
               end else begin
                  chk("deser_word", acc, word_q.pop_front());
               end
            end
         end
      end
   end

   // Offer one word starting at a falling edge; returns at the falling edge after acceptance
   // with valid still high so the next call can stream back-to-back.
   task automatic send(input logic [D*S-1:0] w);
      bit done;
      done      = 1'b0;
      data_in   = w;
      din_valid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         if (din_ready === 1'b1) begin
            @(posedge clk);
            for (int k = 0; k < S; k++) slice_q.push_back(w[D*k +: D]);
            word_q.push_back(w);
            done = 1'b1;
         end else begin
            @(posedge clk);
         end
         @(negedge clk);
      end
      chk("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) begin
         data_in = $urandom;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_data_out", 32'(dout), 32'(IDLE_EXP));
      chk("rst_out_valid", 32'(dout_valid), 32'd0);
      chk("rst_in_ready", 32'(din_ready), 32'd1);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Single word
      send(32'h44332211);
      idle(8);

      // Two words back-to-back; second one waits in the buffer
      send(32'h44332211);
      send(32'h88776655);
      chk("ready_while_buffered", 32'(din_ready), 32'd0);
      idle(10);

      // Three words with a valid gap before the third
      send(32'h0C0B0A09);
      send(32'h1D1C1B1A);
      idle(6);
      send(32'h2E2D2C2B);
      idle(12);

      // Asynchronous reset during slice 2 with the buffer full
      send(32'h13121110);
      send(32'h17161514);
      din_valid = 1'b0;
      chk("t4_ready_full", 32'(din_ready), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_async_data", 32'(dout), 32'(IDLE_EXP));
      chk("t4_async_valid", 32'(dout_valid), 32'd0);
      chk("t4_async_ready", 32'(din_ready), 32'd1);
      slice_q.delete();
      word_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t4_ready_after", 32'(din_ready), 32'd1);
      send(32'hDDCCBBAA);
      idle(10);

      // Loopback with random words and random gaps
      for (int i = 0; i < 100; i++) begin
         send($urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
      end
      idle(12);

      chk("slices_drained", 32'(slice_q.size()), 32'd0);
      chk("words_drained", 32'(word_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
